// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle between an external controller and the register-file peripheral.
// The master modport is the controller side; the slave modport is the peripheral side.
interface spi_regfile_peripheral_if;
  logic cs_n;
  logic sclk;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output cs_n, sclk, copi, input cipo, cipo_oe);
  modport slave  (input cs_n, sclk, copi, output cipo, cipo_oe);
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file peripheral, all pins oversampled in the clk domain.
// Writes commit 3 clk edges after cs_n is first sampled high; no backpressure, sclk <= clk/8.
module spi_regfile_peripheral #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_peripheral_if.slave    spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int CMD_LEN   = 1 + ADDR_W;
  localparam int FRAME_LEN = CMD_LEN + DATA_W;
  localparam int CNT_MAX   = FRAME_LEN + 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  state_t               state, state_nx;
  logic [2:0]           cs_s, sclk_s;
  logic [1:0]           copi_s;
  logic [1:0]           sync_vld;
  logic                 armed;
  logic                 cs_fall, cs_rise, sclk_rise, sclk_fall, rise_ev, fall_ev, copi_b;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_LEN-1:0] sh;
  logic [DATA_W-1:0]    rd_sh, rd_word;
  logic                 oe_q;
  logic [ADDR_W:0]      hdr;
  logic                 hdr_rw;
  logic [ADDR_W-1:0]    hdr_addr, fr_addr, commit_addr;
  logic                 fr_rw, frame_ok, addr_ok, end_frame;
  logic [DATA_W-1:0]    fr_dat, commit_dat;
  logic                 commit_wr_nx, commit_err_nx, commit_wr, commit_err;
  logic [DATA_W-1:0]    regs [NUM_REGS];

  // sync_vld tracks when cs_s[1] holds a real pin sample; armed then requires a genuine
  // high level so a frame already under way at reset release is never joined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s     <= 3'b111;
      sclk_s   <= '0;
      copi_s   <= '0;
      sync_vld <= '0;
      armed    <= 1'b0;
    end else begin
      cs_s     <= {cs_s[1:0], spi.cs_n};
      sclk_s   <= {sclk_s[1:0], spi.sclk};
      copi_s   <= {copi_s[0], spi.copi};
      sync_vld <= {sync_vld[0], 1'b1};
      armed    <= armed | (sync_vld[1] & cs_s[1]);
    end
  end

  assign cs_fall   = armed & cs_s[2] & ~cs_s[1];
  assign cs_rise   = ~cs_s[2] & cs_s[1];
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign rise_ev   = sclk_rise & ~cs_rise;
  assign fall_ev   = sclk_fall & ~cs_rise;
  assign copi_b    = copi_s[1];

  // Header as it stands including the bit arriving on this rising edge.
  assign hdr      = {sh[ADDR_W-1:0], copi_b};
  assign hdr_rw   = hdr[ADDR_W];
  assign hdr_addr = hdr[ADDR_W-1:0];

  assign fr_rw     = sh[FRAME_LEN-1];
  assign fr_addr   = sh[DATA_W +: ADDR_W];
  assign fr_dat    = sh[DATA_W-1:0];
  assign frame_ok  = (cnt == CNT_W'(FRAME_LEN));
  assign addr_ok   = ({1'b0, fr_addr} < (ADDR_W+1)'(NUM_REGS));
  assign end_frame = (state != S_IDLE) && cs_rise;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hdr_addr == ADDR_W'(i)) rd_word = regs[i];
    end
  end

  always_comb begin
    state_nx      = state;
    commit_wr_nx  = 1'b0;
    commit_err_nx = 1'b0;
    case (state)
      S_IDLE: if (cs_fall) state_nx = S_CMD;
      S_CMD: begin
        if (cs_rise) state_nx = S_IDLE;
        else if (rise_ev && cnt == CNT_W'(CMD_LEN - 1)) state_nx = S_DATA;
      end
      S_DATA: begin
        if (cs_rise) state_nx = S_IDLE;
        else if (rise_ev && cnt == CNT_W'(FRAME_LEN - 1)) state_nx = S_DONE;
      end
      S_DONE: if (cs_rise) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (end_frame) begin
      commit_wr_nx  = frame_ok & fr_rw & addr_ok;
      commit_err_nx = ~frame_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      sh          <= '0;
      rd_sh       <= '0;
      oe_q        <= 1'b0;
      commit_wr   <= 1'b0;
      commit_err  <= 1'b0;
      commit_addr <= '0;
      commit_dat  <= '0;
      wr_strobe   <= 1'b0;
      frame_err   <= 1'b0;
      wr_addr     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (state == S_IDLE) cnt <= '0;
      else if (rise_ev && cnt != CNT_W'(CNT_MAX)) cnt <= cnt + CNT_W'(1);

      if (state != S_IDLE && rise_ev) sh <= {sh[FRAME_LEN-2:0], copi_b};

      // The falling edge right after the last header bit must not shift: the MSB has
      // to stay on cipo until the controller samples it on the first data rising edge.
      if (state == S_CMD && state_nx == S_DATA) rd_sh <= rd_word;
      else if (state == S_DATA && fall_ev && cnt > CNT_W'(CMD_LEN)) rd_sh <= rd_sh << 1;

      oe_q <= (state_nx == S_DATA) && ((state == S_DATA) ? oe_q : ~hdr_rw);

      commit_wr  <= commit_wr_nx;
      commit_err <= commit_err_nx;
      if (commit_wr_nx) begin
        commit_addr <= fr_addr;
        commit_dat  <= fr_dat;
      end

      wr_strobe <= commit_wr;
      frame_err <= commit_err;
      if (commit_wr) begin
        wr_addr <= commit_addr;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (commit_addr == ADDR_W'(i)) regs[i] <= commit_dat;
        end
      end
    end
  end

  assign spi.cipo_oe = oe_q;
  assign spi.cipo    = oe_q & rd_sh[DATA_W-1];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Bench for spi_regfile_peripheral: directed and random SPI frames against a register-array
// model; expected commit/error events are queued and checked by an independent monitor.
module tb_spi_regfile_peripheral;
  localparam int NUM_REGS  = 5;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 7;
  localparam int CMD_LEN   = 1 + ADDR_W;
  localparam int FRAME_LEN = CMD_LEN + DATA_W;
  localparam int HALF      = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_regfile_peripheral_if spi ();
  logic [NUM_REGS*DATA_W-1:0] regs_o;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       frame_err;

  spi_regfile_peripheral #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi),
    .regs_o    (regs_o),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  typedef struct {
    bit                         err;
    logic [ADDR_W-1:0]          addr;
    logic [NUM_REGS*DATA_W-1:0] regs;
  } ev_t;

  ev_t             evq[$];
  ev_t             mon_ev;
  logic [DATA_W-1:0] model [NUM_REGS];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] model_vec();
    logic [NUM_REGS*DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = model[i];
    return v;
  endfunction

  task automatic chk_reset_state();
    chk("rst_regs_o", regs_o, '0);
    chk("rst_cipo", spi.cipo, 0);
    chk("rst_cipo_oe", spi.cipo_oe, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_frame_err", frame_err, 0);
  endtask

  // Monitor: every strobe/error pulse must match the next queued expectation and arrive
  // exactly 3 edges after the first edge that saw cs_n high.
  int   pcnt    = 0;
  int   rise_at = -100;
  logic cs_prev = 1'b1;
  always @(posedge clk) begin
    #1;
    pcnt++;
    if (spi.cs_n === 1'b1 && cs_prev === 1'b0) rise_at = pcnt;
    cs_prev = spi.cs_n;
    if (wr_strobe || frame_err) begin
      chk("event_expected", evq.size() != 0, 1);
      if (evq.size() != 0) begin
        mon_ev = evq.pop_front();
        chk("event_kind", {wr_strobe, frame_err}, mon_ev.err ? 2'b01 : 2'b10);
        chk("event_latency", pcnt - rise_at, 3);
        if (!mon_ev.err) begin
          chk("wr_addr", wr_addr, mon_ev.addr);
          chk("regs_at_strobe", regs_o, mon_ev.regs);
        end
      end
    end
  end

  // Sends the len low bits of 'bits' MSB first; rst_at >= 0 pulses reset before that bit.
  task automatic run_frame(input logic [31:0] bits, input int len, input int rst_at, input int gap);
    logic [31:0]       hdr;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_rd, got_rd;
    logic              exp_oe;
    int                oe_bad;
    bit                did_rst;
    ev_t               e;
    rw = 1'b1; addr = '0;
    if (len >= CMD_LEN) begin
      hdr  = bits >> (len - CMD_LEN);
      rw   = hdr[ADDR_W];
      addr = hdr[ADDR_W-1:0];
    end else if (len > 0) begin
      rw = bits[len-1];
    end
    exp_rd = '0;
    if (int'(addr) < NUM_REGS) exp_rd = model[addr];
    got_rd = '0; oe_bad = 0; did_rst = 0;

    spi.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        for (int r = 0; r < NUM_REGS; r++) model[r] = '0;
        rst_n = 1'b1;
        did_rst = 1;
        repeat (2) @(negedge clk);
      end
      spi.copi = bits[len-1-i];
      repeat (HALF) @(negedge clk);
      exp_oe = !did_rst && !rw && i >= CMD_LEN && i < FRAME_LEN;
      if (spi.cipo_oe !== exp_oe) oe_bad++;
      if (spi.cipo_oe !== 1'b1 && spi.cipo !== 1'b0) oe_bad++;
      if (exp_oe) got_rd = {got_rd[DATA_W-2:0], spi.cipo};
      spi.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);

    if (!did_rst) begin
      if (len != FRAME_LEN) begin
        e.err = 1; e.addr = '0; e.regs = model_vec();
        evq.push_back(e);
      end else if (rw && int'(addr) < NUM_REGS) begin
        model[addr] = bits[DATA_W-1:0];
        e.err = 0; e.addr = addr; e.regs = model_vec();
        evq.push_back(e);
      end
    end
    spi.cs_n = 1'b1;
    chk("cipo_oe_frame", oe_bad, 0);
    if (!did_rst && !rw && len >= FRAME_LEN) chk("read_data", got_rd, exp_rd);
    repeat (gap) @(negedge clk);
  endtask

  task automatic rand_frame();
    int                kind, len, extra;
    logic              rw;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [31:0]       bits;
    kind = $urandom_range(0, 5);
    rw   = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) a = ADDR_W'($urandom_range(0, 127));
    else                           a = ADDR_W'($urandom_range(0, NUM_REGS - 1));
    d    = DATA_W'($urandom);
    bits = 32'({rw, a, d});
    len  = FRAME_LEN;
    if (kind == 4) begin
      len  = $urandom_range(1, FRAME_LEN - 1);
      bits = bits >> (FRAME_LEN - len);
    end else if (kind == 5) begin
      extra = $urandom_range(1, 4);
      len   = FRAME_LEN + extra;
      bits  = (bits << extra) | 32'($urandom_range(0, (1 << extra) - 1));
    end
    run_frame(bits, len, -1, $urandom_range(1, 6));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    spi.cs_n = 1'b1;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) model[r] = '0;
    repeat (3) @(negedge clk);
    chk_reset_state();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_frame(32'h80A5, 16, -1, 6);
    run_frame(32'h843C, 16, -1, 6);
    run_frame(32'h0400, 16, -1, 6);
    run_frame(32'h85FF, 16, -1, 6);
    run_frame(32'h0500, 16, -1, 6);
    run_frame(32'h81FF >> 6, 10, -1, 6);
    run_frame((32'h80A5 << 1) | 32'h1, 17, -1, 6);
    run_frame(32'h8111, 16, -1, 1);
    run_frame(32'h8222, 16, -1, 8);
    chk("regs_after_b2b", regs_o, model_vec());
    run_frame(32'h8377, 16, 8, 8);
    chk("regs_after_midframe_reset", regs_o, '0);

    for (int n = 0; n < 40; n++) rand_frame();

    repeat (20) @(negedge clk);
    chk("queue_drained", evq.size(), 0);
    chk("regs_final", regs_o, model_vec());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_regfile_peripheral.md
Name: spi_regfile_peripheral

Overview:
- SPI mode-0 peripheral giving an external controller write and read access to a parametrised bank of control registers.
- All SPI pins (sclk, copi, cs_n) are oversampled in the system clk domain through 2-FF synchronisers with edge detection; no logic is clocked by sclk.
- Successor to the fixed 5x8-bit write-only peripheral. Adds:
  - configurable register count and width
  - readback on cipo
  - persistent register contents
  - strict frame-length checking with abort
  - a write strobe toward PWM and other consumers.

Parameters:
- NUM_REGS, 5, number of registers; legal range 1..2**ADDR_W.
- DATA_W, 8, register width in bits; legal range 1..16.
- ADDR_W, 7, address field width in bits.

Ports:
- clk  in  1  system clock; sclk frequency must be at most clk/8.
- rst_n  in  1  asynchronous active-low reset.
- cs_n  in  1  chip select, active low, asynchronous to clk.
- sclk  in  1  SPI clock from controller, asynchronous to clk.
- copi  in  1  controller-out peripheral-in, asynchronous to clk.
- cipo  out  1  peripheral-out controller-in read data.
- cipo_oe  out  1  high while the selected frame is a read in the DATA phase (pad tristate control).
- regs_o  out  NUM_REGS*DATA_W  flattened register bank; register i occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  out  1  one-clk pulse when a write commits.
- wr_addr  out  ADDR_W  address of the last committed write; valid while wr_strobe is high.
- frame_err  out  1  one-clk pulse when a frame is discarded.

Behaviour:
- Reset (async, rst_n low):
  - regs_o, cipo, cipo_oe, wr_strobe, wr_addr, frame_err = 0.
  - Synchroniser flops = 0 (the cs_n synchroniser resets to 1).
  - FSM returns to IDLE; bit counter and shift registers are cleared.
  - Reset asserted mid-frame discards the frame. After release, the FSM stays in IDLE until a synchronised cs_n falling edge; a frame already in progress is never joined.
- Synchronisation and edge detection:
  - cs_n, sclk and copi each pass through 2 FFs, plus a third FF for edge detection.
  - copi is sampled on the detected sclk rising edge. cipo is updated on the detected sclk falling edge.
- Frame format (MSB first): 1 R/W bit (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits. FRAME_LEN = 1 + ADDR_W + DATA_W (16 at defaults).
- FSM states:
  - IDLE: on cs_n fall, go to CMD and clear the counter.
  - CMD: shift in R/W and address; after 1 + ADDR_W rising edges go to DATA.
  - DATA: count DATA_W rising edges, then go to DONE.
  - DONE: wait for cs_n rise.
  - Any state except IDLE: on cs_n rise go to IDLE.
- Read path:
  - On entering DATA with R/W = 0, load the read shift register with reg[addr]. Load all zeros if addr >= NUM_REGS.
  - Assert cipo_oe and drive the MSB on cipo immediately.
  - Shift the next bit out on each sclk falling edge.
  - cipo_oe deasserts in IDLE and DONE.
  - cipo = 0 whenever cipo_oe = 0.
- Commit on synchronised cs_n rising edge:
  - Bit count == FRAME_LEN, write, addr < NUM_REGS: update reg[addr], pulse wr_strobe, set wr_addr. regs_o changes in the same clk cycle as wr_strobe.
  - Bit count == FRAME_LEN, write, addr >= NUM_REGS: no update, no strobe, no error pulse.
  - Bit count == FRAME_LEN, read: no side effects.
  - Bit count != FRAME_LEN (short, or extra sclk rising edges in DONE): discard and pulse frame_err; a read is also flagged.
- Latency: wr_strobe and frame_err assert exactly 3 clk rising edges after the first clk edge that samples cs_n high.
- Register persistence: registers hold their value across frames and are modified only by a committed write. Writes to one address never disturb any other register.
- Simultaneous events:
  - A cs_n rise in the same clk cycle as a detected sclk edge: cs_n wins; the edge is ignored.
  - A cs_n fall in the cycle after a commit: a new frame starts normally.
  - Back-to-back frames with one clk of cs_n high are supported.
- Counter: sized for FRAME_LEN + 1. It saturates at FRAME_LEN + 1 so any overlong frame is flagged and never wraps to a valid count.

Test Plan:
- Reset: assert rst_n low mid-operation -> all regs_o 0, all outputs 0; frame in progress discarded with no frame_err.
- Write reg 0: 16-bit write frame 0x80A5 (W, addr 0, data 0xA5) -> reg0 = 0xA5, other registers 0; wr_strobe 1 clk with wr_addr = 0; no frame_err.
- Write then read back: write 0x843C (addr 4, data 0x3C), then read frame 0x0400 -> cipo shifts out 0x3C MSB first during the DATA phase with cipo_oe high; reg4 still 0x3C; no wr_strobe on the read.
- Out-of-range address: write frame 0x85FF (addr 5) -> regs_o unchanged, no wr_strobe, no frame_err. Read of addr 5 returns 0x00.
- Abort and overlong frames: write frame with cs_n raised after 10 bits -> frame_err pulse, regs unchanged. A 17-bit frame 0x80A5 plus one extra bit -> frame_err, reg0 unchanged.
- Back-to-back and persistence: write reg1 = 0x11, then reg2 = 0x22 with 1 clk of cs_n high between frames -> both commit; reg1 still 0x11 after the second frame; two wr_strobe pulses.
